// File: rtl/des_sbox_bank_pkg.sv
// des_pkg: shared constants and helpers for the DES S-box bank.
//   SBOX        - S1..S8 substitution tables, entry index = row*16 + col
//   P_TAB       - DES P permutation, 1-based source bit for each output bit
//   sbox_lookup - 4-bit lookup for one 6-bit group of a given box
//   p_perm      - applies P to a 32-bit S-box result
//   state_t     - bank FSM states
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Outer bits {b1,b6} pick the row, inner bits b2..b5 the column.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box_idx, input logic [5:0] six);
        logic [5:0] idx;
        idx = {six[5], six[0], six[4:1]};
        return 4'(SBOX[box_idx][idx]);
    endfunction

    // Bit numbering is 1-based from the MSB, so DES bit j lives at x[32-j].
    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            y[31-i] = x[32-P_TAB[i]];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_bank_if.sv
// des_sbox_bank_if: valid/ready input and output channels of the S-box bank.
//   in_valid/in_ready/in_data    - 48-bit keyed half-block from the key-mix XOR
//   out_valid/out_ready/out_data - 32-bit substituted (optionally P-permuted) word
//   busy                         - bank is stepping through its lookups
// slave is the bank side, master the producer/consumer side.
interface des_sbox_bank_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_sbox_bank_lane.sv
// des_sbox_lane: one combinational S-box lookup.
//   box_idx - which of S1..S8 (0 = S1)
//   six     - 6-bit input group, MSB = b1
//   nibble  - 4-bit substitution result
module des_sbox_lane
    import des_pkg::*;
(
    input  logic [2:0] box_idx,
    input  logic [5:0] six,
    output logic [3:0] nibble
);
    assign nibble = sbox_lookup(box_idx, six);
endmodule

// File: rtl/des_sbox_bank.sv
// des_sbox_bank: multi-lane DES S-box engine, LANES lookups per BUSY cycle.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of des_sbox_bank_if (in_*, out_*, busy)
// A 48-bit input is captured in IDLE (or in DONE while the previous result is
// being taken), resolved over 8/LANES BUSY cycles, and held in DONE until the
// consumer accepts it.
module des_sbox_bank
    import des_pkg::*;
#(
    parameter int LANES   = 8,
    parameter bit PERM_EN = 1'b0
)
(
    input  logic            clk,
    input  logic            rst_n,
    des_sbox_bank_if.slave  bus
);
    localparam int STEPS    = 8 / LANES;
    localparam int CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int CNT_LAST = STEPS - 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_bank: LANES must be 1, 2, 4 or 8");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [47:0]        r_src;
    logic [31:0]        r_res;
    logic [31:0]        r_out;
    logic [31:0]        w_res_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [2:0]         w_box [LANES];
    logic [5:0]         w_six [LANES];
    logic [3:0]         w_nib [LANES];

    // Lane k handles box cnt*LANES + k; its 6-bit group sits MSB-first in r_src.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_box[k] = 3'(int'(r_cnt) * LANES + k);
        assign w_six[k] = r_src[47 - 6 * int'(w_box[k]) -: 6];
        des_sbox_lane u_lane (
            .box_idx (w_box[k]),
            .six     (w_six[k]),
            .nibble  (w_nib[k])
        );
    end

    always_comb begin
        w_res_nxt = r_res;
        for (int k = 0; k < LANES; k++) begin
            w_res_nxt[31 - 4 * int'(w_box[k]) -: 4] = w_nib[k];
        end
    end

    assign w_last = (r_cnt == CNT_W'(CNT_LAST));

    // Next state; in DONE the input side only opens once the output is taken,
    // which lets a waiting input slip in on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_in_ready  = 1'b1;
                    w_state_nxt = bus.in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_res   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_src <= bus.in_data;
                r_res <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_BUSY) begin
                r_res <= w_res_nxt;
                if (w_last) begin
                    r_out <= PERM_EN ? p_perm(w_res_nxt) : w_res_nxt;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.out_data  = r_out;

endmodule

// File: tb/tb_des_sbox_bank.sv
// Bench for des_sbox_bank: four instances (8 lanes raw, 1 lane raw,
// 2 lanes P-permuted, 4 lanes raw) share in_valid/in_data; each has its own
// out_ready and rst_n. A per-instance scoreboard predicts every accepted
// block from FIPS 46-3 tables held here and checks data, latency and hold.
module tb_des_sbox_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n_v;
    logic        tb_in_valid;
    logic [47:0] tb_in_data;
    logic [3:0]  tb_out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    des_sbox_bank_if bus8();
    des_sbox_bank_if bus1();
    des_sbox_bank_if bus2();
    des_sbox_bank_if bus4();

    assign bus8.in_valid = tb_in_valid;  assign bus8.in_data = tb_in_data;  assign bus8.out_ready = tb_out_ready[0];
    assign bus1.in_valid = tb_in_valid;  assign bus1.in_data = tb_in_data;  assign bus1.out_ready = tb_out_ready[1];
    assign bus2.in_valid = tb_in_valid;  assign bus2.in_data = tb_in_data;  assign bus2.out_ready = tb_out_ready[2];
    assign bus4.in_valid = tb_in_valid;  assign bus4.in_data = tb_in_data;  assign bus4.out_ready = tb_out_ready[3];

    des_sbox_bank #(.LANES(8), .PERM_EN(1'b0)) u_l8  (.clk(clk), .rst_n(rst_n_v[0]), .bus(bus8));
    des_sbox_bank #(.LANES(1), .PERM_EN(1'b0)) u_l1  (.clk(clk), .rst_n(rst_n_v[1]), .bus(bus1));
    des_sbox_bank #(.LANES(2), .PERM_EN(1'b1)) u_l2p (.clk(clk), .rst_n(rst_n_v[2]), .bus(bus2));
    des_sbox_bank #(.LANES(4), .PERM_EN(1'b0)) u_l4  (.clk(clk), .rst_n(rst_n_v[3]), .bus(bus4));

    // Each box as 64 nibbles, row-major (row 0 col 0 in the top nibble).
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    localparam int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int LANES_OF [4] = '{8, 1, 2, 4};
    localparam bit PERM_OF  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    function automatic logic [3:0] ref_sbox(int b, int six);
        int row;
        int col;
        int e;
        logic [255:0] t;
        row = ((six >> 5) & 1) * 2 + (six & 1);
        col = (six >> 1) & 15;
        e   = row * 16 + col;
        t   = SB[b];
        return t[255 - 4*e -: 4];
    endfunction

    function automatic logic [31:0] ref_model(logic [47:0] d, bit perm);
        logic [31:0] r;
        logic [31:0] p;
        logic [47:0] t;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            t = d >> (42 - 6*b);
            r = {r[27:0], ref_sbox(b, int'(t[5:0]))};
        end
        if (!perm) return r;
        p = '0;
        for (int i = 0; i < 32; i++) p[31-i] = r[32 - PT[i]];
        return p;
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state per instance.
    logic [31:0] exp_q [4][$];
    int          acc_q [4][$];
    bit          prev_ov   [4];
    bit          prev_ordy [4];
    logic [31:0] prev_od   [4];
    logic [31:0] last_out  [4];
    int          out_cnt   [4];

    task automatic mon(int id, logic rstn, logic acc, logic [47:0] din,
                       logic ov, logic ordy, logic [31:0] od);
        int a;
        if (!rstn) begin
            exp_q[id].delete();
            acc_q[id].delete();
            prev_ov[id]   = 1'b0;
            prev_ordy[id] = 1'b1;
            return;
        end
        if (prev_ov[id] && !prev_ordy[id]) begin
            check_eq($sformatf("hold_valid%0d", id), 64'(ov), 64'd1);
            check_eq($sformatf("hold_data%0d", id), 64'(od), 64'(prev_od[id]));
        end
        if (ov && !prev_ov[id]) begin
            check_eq($sformatf("rise_pending%0d", id), 64'(acc_q[id].size() > 0), 64'd1);
            if (acc_q[id].size() > 0) begin
                a = acc_q[id].pop_front();
                check_eq($sformatf("latency%0d", id), 64'(cyc), 64'(a + 8 / LANES_OF[id] + 1));
            end
        end
        if (ov && ordy) begin
            check_eq($sformatf("out_pending%0d", id), 64'(exp_q[id].size() > 0), 64'd1);
            if (exp_q[id].size() > 0)
                check_eq($sformatf("data%0d", id), 64'(od), 64'(exp_q[id].pop_front()));
            last_out[id] = od;
            out_cnt[id]++;
        end
        if (acc) begin
            exp_q[id].push_back(ref_model(din, PERM_OF[id]));
            acc_q[id].push_back(cyc);
        end
        prev_ov[id]   = ov;
        prev_ordy[id] = ordy;
        prev_od[id]   = od;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, rst_n_v[0], bus8.in_valid & bus8.in_ready, bus8.in_data, bus8.out_valid, bus8.out_ready, bus8.out_data);
        mon(1, rst_n_v[1], bus1.in_valid & bus1.in_ready, bus1.in_data, bus1.out_valid, bus1.out_ready, bus1.out_data);
        mon(2, rst_n_v[2], bus2.in_valid & bus2.in_ready, bus2.in_data, bus2.out_valid, bus2.out_ready, bus2.out_data);
        mon(3, rst_n_v[3], bus4.in_valid & bus4.in_ready, bus4.in_data, bus4.out_valid, bus4.out_ready, bus4.out_data);
    end

    // One-edge input pulse; returns 1 time unit after the accept edge.
    task automatic send(logic [47:0] d);
        @(posedge clk); #1;
        tb_in_valid = 1'b1;
        tb_in_data  = d;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_eq("drain_in_time", 64'(t < 200), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy_n;
        bit          rdy_in_busy;
        int          w;
        int          oc;
        logic [31:0] od0;
        logic [47:0] d2;

        for (int i = 0; i < 4; i++) begin
            prev_ov[i] = 1'b0; prev_ordy[i] = 1'b1; prev_od[i] = '0;
            last_out[i] = '0; out_cnt[i] = 0;
        end
        rst_n_v      = '0;
        tb_in_valid  = 1'b0;
        tb_in_data   = '0;
        tb_out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n_v = '1;

        check_eq("rst_in_ready",  64'(bus8.in_ready),  64'd1);
        check_eq("rst_out_valid", 64'(bus1.out_valid), 64'd0);
        check_eq("rst_out_data",  64'(bus4.out_data),  64'd0);
        check_eq("rst_busy",      64'(bus2.busy),      64'd0);

        send(48'h000000000000);
        drain();
        check_eq("l8_zero", 64'(last_out[0]), 64'hEFA72C4D);

        send(48'hFFFFFFFFFFFF);
        busy_n = 0;
        rdy_in_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            busy_n += int'(bus1.busy);
            if (bus1.busy && bus1.in_ready) rdy_in_busy = 1'b1;
        end
        @(posedge clk); #1;
        drain();
        check_eq("l1_busy_cycles", 64'(busy_n), 64'd8);
        check_eq("l1_ready_in_busy", 64'(rdy_in_busy), 64'd0);
        check_eq("l1_ones", 64'(last_out[1]), 64'hD9CE3DCB);

        send(48'h6117BA866527);
        drain();
        check_eq("l2_fips_perm", 64'(last_out[2]), 64'h234AA9BB);
        check_eq("l8_fips_raw",  64'(last_out[0]), 64'h5C82B597);
        check_eq("l1_fips_raw",  64'(last_out[1]), 64'h5C82B597);

        for (int g = 0; g < 8; g++) begin
            for (int v = 0; v < 64; v++) begin
                send(48'(v) << (6 * (7 - g)));
            end
        end
        drain();

        // Backpressure on the 4-lane instance, then back-to-back capture.
        tb_out_ready[3] = 1'b0;
        send({16'($urandom), $urandom});
        w = 0;
        while (!bus4.out_valid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("bp_valid", 64'(bus4.out_valid), 64'd1);
        od0 = bus4.out_data;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("bp_valid_held", 64'(bus4.out_valid), 64'd1);
        check_eq("bp_data_held",  64'(bus4.out_data),  64'(od0));
        d2 = {16'($urandom), $urandom};
        tb_in_valid = 1'b1;
        tb_in_data  = d2;
        @(posedge clk); #1;
        tb_out_ready[3] = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        check_eq("b2b_busy",     64'(bus4.busy),      64'd1);
        check_eq("b2b_no_valid", 64'(bus4.out_valid), 64'd0);
        drain();
        check_eq("b2b_result", 64'(last_out[3]), 64'(ref_model(d2, 1'b0)));

        // Reset the 1-lane instance while its counter sits at 4.
        send({16'($urandom), $urandom});
        repeat (4) @(posedge clk);
        #1;
        rst_n_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n_v[1] = 1'b1;
        check_eq("mid_rst_busy",      64'(bus1.busy),      64'd0);
        check_eq("mid_rst_out_valid", 64'(bus1.out_valid), 64'd0);
        check_eq("mid_rst_out_data",  64'(bus1.out_data),  64'd0);
        check_eq("mid_rst_in_ready",  64'(bus1.in_ready),  64'd1);
        oc = out_cnt[1];
        repeat (15) @(posedge clk);
        #1;
        check_eq("mid_rst_discard", 64'(out_cnt[1]), 64'(oc));
        drain();

        repeat (400) begin
            @(posedge clk); #1;
            tb_in_valid  = 1'($urandom);
            tb_in_data   = {16'($urandom), $urandom};
            tb_out_ready = 4'($urandom);
        end
        @(posedge clk); #1;
        tb_in_valid  = 1'b0;
        tb_out_ready = '1;
        drain();

        for (int i = 0; i < 4; i++)
            check_eq($sformatf("final_empty%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_sbox_bank.md
Name: des_sbox_bank

Overview:
- Multi-lane DES substitution engine: takes a 48-bit expanded-and-keyed half-block, runs it through S-boxes S1..S8 and returns the 32-bit result, optionally passed through the DES P permutation.
- LANES S-box lookups happen per cycle, so area and latency trade off from 1 lane/8 cycles to 8 lanes/1 cycle.
- Sits between the key-mix XOR and the round-function output in the round datapath.
- Valid/ready handshake on both sides.

Parameters:
- LANES, 8, S-box lookups per BUSY cycle; legal values 1, 2, 4, 8; any other value is an elaboration error.
- PERM_EN, 0, 1 = apply DES P permutation to out_data; 0 = raw S1..S8 concatenation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data.
- in_data  in  48  bits [48:43] to S1, [42:37] to S2, …, [6:1] to S8.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  32  bits [32:29] = S1 … [4:1] = S8, P-permuted when PERM_EN = 1.
- busy  out  1  high in BUSY.

Behaviour:
- Lookup addressing (standard DES), for a 6-bit group b1..b6 with b1 as MSB:
  - row = {b1,b6}, col = {b2,b3,b4,b5}.
  - S1(000000) = 14; S1(000001) = 0 (row 1, col 0).
- FSM states: IDLE, BUSY, DONE. A counter cnt counts 0..8/LANES-1.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into src_q, clear res_q, set cnt = 0, go to BUSY.
- BUSY:
  - Each cycle, lanes k = 0..LANES-1 look up box index cnt*LANES + k on the matching 6-bit group of src_q.
  - Their nibbles are written into the matching positions of res_q.
  - When cnt reaches 8/LANES-1, load out_data from the completed result (P-permuted if PERM_EN) in the same edge and go to DONE.
  - Otherwise increment cnt.
- DONE:
  - out_valid = 1.
  - out_data is held stable until out_valid & out_ready.
- Latency: accept at edge N gives out_valid high from cycle N + 8/LANES + 1. Examples: LANES = 8 gives 2 cycles; LANES = 1 gives 9 cycles.
- Back-to-back: in_ready = IDLE | (DONE & out_ready).
  - In DONE with out_ready & in_valid, the output handshake completes and the new input is captured in the same edge; go directly to BUSY.
  - In DONE with out_ready & !in_valid, go to IDLE.
- Outputs stay stable while out_valid & !out_ready; in_data is ignored in BUSY.
- Reset (rst_n = 0 at a rising edge), from any state including mid-BUSY:
  - state = IDLE, cnt = 0, src_q = 0, res_q = 0.
  - out_data = 0, out_valid = 0, busy = 0.
  - in_ready is 1 from the first cycle after reset.
  - Any in-flight result is discarded and never emitted.
- Timing of combinational outputs:
  - in_ready depends combinationally on out_ready only in DONE.
  - There is no combinational path from in_data to any output.
- Table content: all S1..S8 entries follow FIPS 46-3; no X or default-propagation paths.

Decomposition:
- Package des_pkg holds:
  - The S1..S8 tables as constant arrays (8x64x4).
  - The P-permutation index table (32 entries).
  - A function sbox_lookup(box_idx[3], six[6]) returning 4 bits, applying the row/col addressing above.
  - State encodings for IDLE, BUSY, DONE.
- One natural sub-module: des_sbox_lane, a purely combinational lookup with inputs box_idx (3 bits) and six (6 bits) and a 4-bit output. It is instantiated LANES times via generate.

Test Plan:
- LANES = 8, PERM_EN = 0, in_data = 48'h000000000000, out_ready = 1 → out_data = 32'hEFA72C4D, out_valid exactly 2 cycles after accept.
- LANES = 1, PERM_EN = 0, in_data = 48'hFFFFFFFFFFFF → out_data = 32'hD9CE3DCB; busy high for 8 cycles; out_valid on cycle 9; in_ready low throughout.
- LANES = 2, PERM_EN = 1, in_data = 48'h6117BA866527 (FIPS worked example, round 1) → out_data = 32'h234AA9BB; same input with PERM_EN = 0 → 32'h5C82B597.
- Backpressure and back-to-back, LANES = 4:
  - Hold out_ready = 0 for 5 cycles → out_data and out_valid stable throughout.
  - Raise out_ready with in_valid already high → new input captured that edge with no idle bubble.
  - Second result appears 3 cycles later.
- Reset mid-BUSY, LANES = 1: assert rst_n = 0 for one edge at cnt = 4 → next cycle state is IDLE, out_valid = 0, out_data = 0, in_ready = 1; the discarded result is never emitted.
- Exhaustive lane check, LANES = 8: sweep all 64 values of each 6-bit group with the other groups held at 0, and compare every nibble against a des_pkg-based model.
